// File: rtl/video_timing_gen_prog.sv
// Programmable video timing generator.
// A config is written into a shadow set and becomes the live timing only at
// the (HT-1, VT-1) -> (0,0) wrap, so a mode switch never tears a frame.
// Every status output is registered from the lookahead position, so all
// outputs describe the (hcount_out, vcount_out) shown on the same cycle.
module video_timing_gen_prog #(
  parameter int H_WIDTH      = 12,
  parameter int V_WIDTH      = 11,
  parameter int FC_WIDTH     = 6,
  parameter bit HS_POL       = 1'b1,
  parameter bit VS_POL       = 1'b1,
  parameter int RST_H_ACTIVE = 1280,
  parameter int RST_H_FP     = 110,
  parameter int RST_H_SYNC   = 40,
  parameter int RST_H_BP     = 220,
  parameter int RST_V_ACTIVE = 720,
  parameter int RST_V_FP     = 5,
  parameter int RST_V_SYNC   = 5,
  parameter int RST_V_BP     = 20,
  parameter int RST_FPS      = 60
) (
  input  logic                pixel_clk_in,
  input  logic                rst_in,
  input  logic                cfg_valid_in,
  input  logic [H_WIDTH-1:0]  cfg_h_active_in,
  input  logic [H_WIDTH-1:0]  cfg_h_fp_in,
  input  logic [H_WIDTH-1:0]  cfg_h_sync_in,
  input  logic [H_WIDTH-1:0]  cfg_h_bp_in,
  input  logic [V_WIDTH-1:0]  cfg_v_active_in,
  input  logic [V_WIDTH-1:0]  cfg_v_fp_in,
  input  logic [V_WIDTH-1:0]  cfg_v_sync_in,
  input  logic [V_WIDTH-1:0]  cfg_v_bp_in,
  input  logic [FC_WIDTH-1:0] cfg_fps_in,
  output logic                cfg_pending_out,
  output logic                cfg_err_out,
  output logic [H_WIDTH-1:0]  hcount_out,
  output logic [V_WIDTH-1:0]  vcount_out,
  output logic                hs_out,
  output logic                vs_out,
  output logic                ad_out,
  output logic                nl_out,
  output logic                nf_out,
  output logic [FC_WIDTH-1:0] fc_out
);

  // Totals are two bits wider than the fields: four fields cannot overflow them.
  localparam int HW2 = H_WIDTH + 2;
  localparam int VW2 = V_WIDTH + 2;
  localparam logic [HW2-1:0] H_MAX = HW2'(1) << H_WIDTH;
  localparam logic [VW2-1:0] V_MAX = VW2'(1) << V_WIDTH;

  typedef struct packed {
    logic [H_WIDTH-1:0]  h_active;
    logic [H_WIDTH-1:0]  h_fp;
    logic [H_WIDTH-1:0]  h_sync;
    logic [H_WIDTH-1:0]  h_bp;
    logic [V_WIDTH-1:0]  v_active;
    logic [V_WIDTH-1:0]  v_fp;
    logic [V_WIDTH-1:0]  v_sync;
    logic [V_WIDTH-1:0]  v_bp;
    logic [FC_WIDTH-1:0] fps;
  } timing_t;

  localparam timing_t RST_TIMING = '{
    h_active: H_WIDTH'(RST_H_ACTIVE), h_fp: H_WIDTH'(RST_H_FP),
    h_sync:   H_WIDTH'(RST_H_SYNC),   h_bp: H_WIDTH'(RST_H_BP),
    v_active: V_WIDTH'(RST_V_ACTIVE), v_fp: V_WIDTH'(RST_V_FP),
    v_sync:   V_WIDTH'(RST_V_SYNC),   v_bp: V_WIDTH'(RST_V_BP),
    fps:      FC_WIDTH'(RST_FPS)
  };

  function automatic logic [HW2-1:0] h_total(input timing_t t);
    return HW2'(t.h_active) + HW2'(t.h_fp) + HW2'(t.h_sync) + HW2'(t.h_bp);
  endfunction

  function automatic logic [VW2-1:0] v_total(input timing_t t);
    return VW2'(t.v_active) + VW2'(t.v_fp) + VW2'(t.v_sync) + VW2'(t.v_bp);
  endfunction

  timing_t             live_q;
  timing_t             shadow_q;
  timing_t             cfg_word;
  timing_t             sel;
  logic [HW2-1:0]      live_ht;
  logic [VW2-1:0]      live_vt;
  logic [HW2-1:0]      hs_start;
  logic [HW2-1:0]      hs_end;
  logic [VW2-1:0]      vs_start;
  logic [VW2-1:0]      vs_end;
  logic                at_line_end;
  logic                at_frame_end;
  logic                commit;
  logic                cfg_accept;
  logic                cfg_reject;
  logic [H_WIDTH-1:0]  next_h;
  logic [V_WIDTH-1:0]  next_v;
  logic                hs_act;
  logic                vs_act;
  logic                ad_nx;
  logic                nf_nx;
  logic [FC_WIDTH-1:0] fc_nx;

  assign cfg_word = '{
    h_active: cfg_h_active_in, h_fp: cfg_h_fp_in,
    h_sync:   cfg_h_sync_in,   h_bp: cfg_h_bp_in,
    v_active: cfg_v_active_in, v_fp: cfg_v_fp_in,
    v_sync:   cfg_v_sync_in,   v_bp: cfg_v_bp_in,
    fps:      cfg_fps_in
  };

  // Validate the strobed set, advance the position, and decode the next position.
  always_comb begin
    cfg_accept   = 1'b0;
    cfg_reject   = 1'b0;
    if (cfg_valid_in) begin
      if ((|cfg_word.h_active) && (|cfg_word.h_sync) &&
          (|cfg_word.v_active) && (|cfg_word.v_sync) && (|cfg_word.fps) &&
          (h_total(cfg_word) <= H_MAX) && (v_total(cfg_word) <= V_MAX))
        cfg_accept = 1'b1;
      else
        cfg_reject = 1'b1;
    end

    live_ht      = h_total(live_q);
    live_vt      = v_total(live_q);
    at_line_end  = (HW2'(hcount_out) == live_ht - HW2'(1));
    at_frame_end = at_line_end && (VW2'(vcount_out) == live_vt - VW2'(1));
    commit       = at_frame_end && cfg_pending_out;

    next_h = at_line_end ? '0 : hcount_out + H_WIDTH'(1);
    next_v = vcount_out;
    if (at_line_end)
      next_v = at_frame_end ? '0 : vcount_out + V_WIDTH'(1);

    // The first position of a committed frame is already decoded with the new set.
    sel = commit ? shadow_q : live_q;

    hs_start = HW2'(sel.h_active) + HW2'(sel.h_fp);
    hs_end   = hs_start + HW2'(sel.h_sync);
    vs_start = VW2'(sel.v_active) + VW2'(sel.v_fp);
    vs_end   = vs_start + VW2'(sel.v_sync);
    hs_act   = (HW2'(next_h) >= hs_start) && (HW2'(next_h) < hs_end);
    vs_act   = (VW2'(next_v) >= vs_start) && (VW2'(next_v) < vs_end);
    ad_nx    = (next_h < sel.h_active) && (next_v < sel.v_active);
    nf_nx    = (next_h == sel.h_active) && (next_v == sel.v_active);

    fc_nx = fc_out;
    if (commit)
      fc_nx = '0;
    else if (nf_nx)
      fc_nx = (fc_out >= sel.fps - FC_WIDTH'(1)) ? '0 : fc_out + FC_WIDTH'(1);
  end

  // Register position, status, shadow/live timing and the config handshake flags.
  always_ff @(posedge pixel_clk_in) begin
    if (rst_in) begin
      live_q          <= RST_TIMING;
      shadow_q        <= '0;
      cfg_pending_out <= 1'b0;
      cfg_err_out     <= 1'b0;
      hcount_out      <= '0;
      vcount_out      <= '0;
      hs_out          <= ~HS_POL;
      vs_out          <= ~VS_POL;
      ad_out          <= 1'b0;
      nl_out          <= 1'b0;
      nf_out          <= 1'b0;
      fc_out          <= '0;
    end else begin
      if (commit)
        live_q <= shadow_q;
      if (cfg_accept)
        shadow_q <= cfg_word;
      if (cfg_accept)
        cfg_pending_out <= 1'b1;
      else if (commit)
        cfg_pending_out <= 1'b0;
      cfg_err_out <= cfg_reject;
      hcount_out  <= next_h;
      vcount_out  <= next_v;
      hs_out      <= hs_act ? HS_POL : ~HS_POL;
      vs_out      <= vs_act ? VS_POL : ~VS_POL;
      ad_out      <= ad_nx;
      nl_out      <= (next_h == '0);
      nf_out      <= nf_nx;
      fc_out      <= fc_nx;
    end
  end

endmodule

// File: tb/tb_video_timing_gen_prog.sv
// Bench for video_timing_gen_prog: small reset timing so whole frames fit in a
// short run; a behavioural position/timing model predicts every output cycle.
module tb_video_timing_gen_prog;

  localparam int  HW = 12;
  localparam int  VW = 11;
  localparam int  FW = 6;
  localparam bit  HSP = 1'b0;
  localparam bit  VSP = 1'b1;
  localparam int  OW = HW + VW + 5 + FW + 2;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          cfg_valid = 1'b0;
  logic [HW-1:0] c_ha = '0, c_hf = '0, c_hs = '0, c_hb = '0;
  logic [VW-1:0] c_va = '0, c_vf = '0, c_vs = '0, c_vb = '0;
  logic [FW-1:0] c_fps = '0;

  logic          cfg_pending, cfg_err, hs, vs, ad, nl, nf;
  logic [HW-1:0] hcount;
  logic [VW-1:0] vcount;
  logic [FW-1:0] fc;

  video_timing_gen_prog #(
    .H_WIDTH(HW), .V_WIDTH(VW), .FC_WIDTH(FW), .HS_POL(HSP), .VS_POL(VSP),
    .RST_H_ACTIVE(20), .RST_H_FP(3), .RST_H_SYNC(4), .RST_H_BP(5),
    .RST_V_ACTIVE(6), .RST_V_FP(2), .RST_V_SYNC(3), .RST_V_BP(4),
    .RST_FPS(4)
  ) dut (
    .pixel_clk_in(clk), .rst_in(rst), .cfg_valid_in(cfg_valid),
    .cfg_h_active_in(c_ha), .cfg_h_fp_in(c_hf), .cfg_h_sync_in(c_hs), .cfg_h_bp_in(c_hb),
    .cfg_v_active_in(c_va), .cfg_v_fp_in(c_vf), .cfg_v_sync_in(c_vs), .cfg_v_bp_in(c_vb),
    .cfg_fps_in(c_fps), .cfg_pending_out(cfg_pending), .cfg_err_out(cfg_err),
    .hcount_out(hcount), .vcount_out(vcount), .hs_out(hs), .vs_out(vs),
    .ad_out(ad), .nl_out(nl), .nf_out(nf), .fc_out(fc)
  );

  // scoreboard
  logic [OW-1:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;
  int n_nf  = 0;
  int n_errp = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // reference model state
  int rst_t[9] = '{20, 3, 4, 5, 6, 2, 3, 4, 4};
  int lt[9];
  int st[9];
  int mh = 0, mv = 0, mfc = 0;
  bit mpend = 1'b0;

  function automatic logic [OW-1:0] pack(int h, int v, bit ohs, bit ovs, bit oad,
                                        bit onl, bit onf, int ofc, bit op, bit oe);
    return {HW'(h), VW'(v), ohs, ovs, oad, onl, onf, FW'(ofc), op, oe};
  endfunction

  function automatic bit model_at_wrap();
    int ht = lt[0] + lt[1] + lt[2] + lt[3];
    int vt = lt[4] + lt[5] + lt[6] + lt[7];
    return (mh == ht - 1) && (mv == vt - 1);
  endfunction

  // Predict the outputs that appear after the coming clock edge.
  task automatic model_step();
    int ht, vt, nh, nv;
    int c[9];
    bit wrap, ok, err, hsa, vsa, oad, onf;
    if (rst) begin
      mh = 0; mv = 0; mfc = 0; mpend = 1'b0;
      lt = rst_t;
      st = '{default: 0};
      exp_q.push_back(pack(0, 0, !HSP, !VSP, 0, 0, 0, 0, 0, 0));
      return;
    end
    ht = lt[0] + lt[1] + lt[2] + lt[3];
    vt = lt[4] + lt[5] + lt[6] + lt[7];
    wrap = (mh == ht - 1) && (mv == vt - 1);
    if (mh == ht - 1) begin
      nh = 0;
      nv = (mv == vt - 1) ? 0 : mv + 1;
    end else begin
      nh = mh + 1;
      nv = mv;
    end
    if (wrap && mpend) begin
      lt = st; mpend = 1'b0; mfc = 0;
    end
    err = 1'b0;
    if (cfg_valid) begin
      c = '{int'(c_ha), int'(c_hf), int'(c_hs), int'(c_hb),
            int'(c_va), int'(c_vf), int'(c_vs), int'(c_vb), int'(c_fps)};
      ok = (c[0] != 0) && (c[2] != 0) && (c[4] != 0) && (c[6] != 0) && (c[8] != 0) &&
           (c[0] + c[1] + c[2] + c[3] <= 4096) && (c[4] + c[5] + c[6] + c[7] <= 2048);
      if (ok) begin
        st = c; mpend = 1'b1;
      end else begin
        err = 1'b1;
      end
    end
    oad = (nh < lt[0]) && (nv < lt[4]);
    hsa = (nh >= lt[0] + lt[1]) && (nh < lt[0] + lt[1] + lt[2]);
    vsa = (nv >= lt[4] + lt[5]) && (nv < lt[4] + lt[5] + lt[6]);
    onf = (nh == lt[0]) && (nv == lt[4]);
    if (onf) mfc = (mfc + 1 >= lt[8]) ? 0 : mfc + 1;
    mh = nh; mv = nv;
    exp_q.push_back(pack(nh, nv, hsa ? HSP : !HSP, vsa ? VSP : !VSP, oad,
                         nh == 0, onf, mfc, mpend, err));
  endtask

  // driver: one clock with current inputs, then compare the produced outputs
  task automatic tick();
    logic [OW-1:0] e;
    model_step();
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check("outputs", 64'({hcount, vcount, hs, vs, ad, nl, nf, fc, cfg_pending, cfg_err}), 64'(e));
    if (nf) n_nf++;
    if (cfg_err) n_errp++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic set_cfg(input int ha, hf, hsn, hb, va, vf, vsn, vb, fps);
    c_ha = HW'(ha); c_hf = HW'(hf); c_hs = HW'(hsn); c_hb = HW'(hb);
    c_va = VW'(va); c_vf = VW'(vf); c_vs = VW'(vsn); c_vb = VW'(vb);
    c_fps = FW'(fps);
  endtask

  task automatic strobe(input int ha, hf, hsn, hb, va, vf, vsn, vb, fps);
    set_cfg(ha, hf, hsn, hb, va, vf, vsn, vb, fps);
    cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
    set_cfg($urandom_range(0, 4095), $urandom_range(0, 4095), $urandom_range(0, 4095),
            $urandom_range(0, 4095), $urandom_range(0, 2047), $urandom_range(0, 2047),
            $urandom_range(0, 2047), $urandom_range(0, 2047), $urandom_range(0, 63));
  endtask

  task automatic run_to_wrap();
    int budget = 5000;
    while (!model_at_wrap() && budget > 0) begin
      tick();
      budget--;
    end
    if (budget == 0) check("wrap_timeout", 64'(1), 64'(0));
  endtask

  initial begin
    // reset held for three cycles
    rst = 1'b1;
    run(3);
    check("rst_hs", 64'(hs), 64'(1));
    check("rst_hcount", 64'(hcount), 64'(0));
    rst = 1'b0;
    tick();
    check("first_hcount", 64'(hcount), 64'(1));
    check("first_ad", 64'(ad), 64'(1));

    // one default frame (32 x 15) then frame counter wrap with fps 4
    n_nf = 0;
    run(32 * 15 - 1);
    check("frame1_nf_count", 64'(n_nf), 64'(1));
    check("frame1_fc", 64'(fc), 64'(1));
    run(32 * 15 * 4);

    // mid-frame strobe of a smaller mode
    run(57);
    strobe(10, 2, 3, 3, 5, 1, 2, 2, 3);
    check("pending_set", 64'(cfg_pending), 64'(1));
    run_to_wrap();
    tick();
    check("commit_pos", 64'({hcount, vcount}), 64'(0));
    check("pending_clr", 64'(cfg_pending), 64'(0));
    run(18 * 10 * 4);

    // two strobes in one frame: the last one wins
    run(23);
    strobe(12, 1, 2, 1, 4, 2, 1, 3, 2);
    run(9);
    strobe(14, 2, 2, 2, 6, 1, 2, 1, 5);
    run_to_wrap();
    run(20 * 10 * 6);

    // rejected strobes leave timing and pending untouched
    n_errp = 0;
    strobe(14, 2, 0, 2, 6, 1, 2, 1, 5);
    run(3);
    strobe(4000, 50, 40, 7, 6, 2, 3, 4, 4);
    run(3);
    strobe(20, 3, 4, 5, 2000, 20, 20, 9, 4);
    run(3);
    strobe(20, 3, 4, 5, 6, 2, 3, 4, 0);
    run(3);
    strobe(20, 3, 4, 5, 0, 2, 3, 4, 4);
    run(3);
    check("err_pulses", 64'(n_errp), 64'(5));
    check("no_pending", 64'(cfg_pending), 64'(0));

    // HT exactly 4096 is accepted, then overwritten before the boundary
    strobe(4000, 50, 40, 6, 6, 2, 3, 4, 4);
    check("max_ht_pending", 64'(cfg_pending), 64'(1));
    run(5);
    strobe(10, 2, 3, 3, 5, 1, 2, 2, 3);
    run_to_wrap();
    run(18 * 10 * 2);

    // strobe landing on the commit cycle goes to the next boundary
    strobe(12, 1, 2, 1, 4, 2, 1, 3, 2);
    run_to_wrap();
    strobe(14, 2, 2, 2, 6, 1, 2, 1, 5);
    check("commit_strobe_pending", 64'(cfg_pending), 64'(1));
    run(16 * 10 * 2);

    // reset in the middle of an active line with a config pending
    strobe(10, 2, 3, 3, 5, 1, 2, 2, 3);
    run(5);
    rst = 1'b1;
    run(3);
    check("midrst_hs", 64'(hs), 64'(1));
    check("midrst_pending", 64'(cfg_pending), 64'(0));
    rst = 1'b0;
    tick();
    check("midrst_first", 64'({hcount, ad}), 64'({12'd1, 1'b1}));
    run(32 * 15 * 2);

    check("queue_empty", 64'(exp_q.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
